param_loader: RTL and testbench
===============================

# param_loader

Streams weights and biases into a bank of neurons over a valid/ready word interface. Words land in a shadow register bank and are committed atomically to the active bank that drives the `w_1`/`w_2`/`b_1`/`b_2` inputs of each two-input tanh neuron. The neurons therefore never see a partially loaded parameter set. The block sits directly upstream of the neuron array, between the host/memory interface and the neuron parameter inputs.

## Interface
- `WIDTH`, 32: signed parameter word width, identical to the neuron datapath width.
- `N_NEURON`, 2: number of neurons fed; each neuron takes 4 words.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `load_start` in, 1: one-cycle request to begin a load.
- `abort` in, 1: cancel an in-progress load.
- `in_valid` in, 1: `in_data` is valid.
- `in_ready` out, 1: block accepts a word this cycle.
- `in_data` in, `WIDTH`: signed parameter word.
- `w1_o`, `w2_o`, `b1_o`, `b2_o` out, `N_NEURON*WIDTH` each: active parameters; neuron k occupies bits `[k*WIDTH +: WIDTH]`.
- `busy` out, 1: high in LOAD and COMMIT.
- `done` out, 1: one-cycle pulse when the new parameter set becomes active.
- `err` out, 1: sticky protocol-error flag.

## Operation
- Word order: neuron 0 first. Per neuron the order is `w_1`, `w_2`, `b_1`, `b_2`. `TOTAL = 4*N_NEURON` words (8 at default).
- States:
  - IDLE: `in_ready=0`. `load_start` moves to LOAD, clears `idx` and clears `err`.
  - LOAD: `in_ready=1`. Each handshake (`in_valid & in_ready`) writes `in_data` to `shadow[idx]` and increments `idx`. The handshake with `idx==TOTAL-1` moves to COMMIT.
  - COMMIT: `in_ready=0`. All shadow words are copied to the active bank at the clock edge that leaves COMMIT. The next state is IDLE.
- `done` is registered. It is high for exactly one cycle: the first cycle in which the outputs show the new set.
- `abort` is honoured in LOAD only. The block returns to IDLE and leaves the active bank untouched. If `abort` and a handshake occur in the same cycle, the word is dropped.
- A `load_start` seen in LOAD or COMMIT is ignored and sets `err`. `err` stays high until the next accepted `load_start` or `rst`.
- No arithmetic is performed. Words are stored bit-exact as signed `WIDTH`-bit values.
- `idx` never wraps, because the block leaves LOAD at `TOTAL-1`.

## Timing
- Reset values: state IDLE, `idx=0`. All active and shadow words are 0. `in_ready=0`, `busy=0`, `done=0`, `err=0`.
- `rst` asserted mid-load returns the block to IDLE with all parameters zeroed. `rst` takes precedence over every other input.
- `in_ready` and `busy` are decoded from the registered state only, with no combinational path from `in_valid`.
- Minimum load latency is `TOTAL+2` cycles from `load_start` to `done`:
  - 1 cycle for IDLE to LOAD.
  - `TOTAL` handshakes.
  - 1 COMMIT cycle.
- Each `in_valid` stall adds 1 cycle.
- Active outputs are constant from reset or the previous commit until the next commit edge.

## Configuration
- `PARAM_READBACK_EN`: when defined, the block adds two ports:
  - `rd_addr` in, `$clog2(TOTAL)` bits.
  - `rd_data` out, `WIDTH` bits, registered; it returns the **active** word at `rd_addr` one cycle later, using the same word ordering. `rd_data` resets to 0, and an out-of-range `rd_addr` returns 0.
- When the macro is undefined, both ports and their logic are absent, and behaviour is otherwise identical.

## Structure
- Shared package `nn_pkg` holds:
  - the state enum `ldr_state_t` (IDLE, LOAD, COMMIT);
  - `WORDS_PER_NEURON = 4`;
  - the word-slot localparams `SLOT_W1=0`, `SLOT_W2=1`, `SLOT_B1=2`, `SLOT_B2=3`.
- One sub-module, `param_shadow_bank`: shadow plus active register arrays with indexed write, a commit strobe and flattened outputs. The FSM, counter and handshake logic stay in `param_loader`.

## Test plan
- Reset, then load 8 words `0x00010000, 0x00020000, 0xFFFF0000, 0x00008000, 0x00030000, 0x00040000, 0x00000000, 0x7FFFFFFF` with `in_valid` held high. Required response:
  - `done` pulses in cycle 10 after `load_start`.
  - `w1_o[0]=0x00010000`, `b2_o[1]=0x7FFFFFFF`.
  - Outputs stay 0 until the `done` cycle.
- Same load with `in_valid` low on alternate cycles. Required response: `done` delayed by exactly 7 cycles; identical final values.
- Commit set A, then start set B and assert `abort` after 5 words. Required response: outputs remain set A, `done` never pulses, state IDLE.
- Assert `load_start` at word 3 of a load. Required response: `err=1`, load completes normally, and `err` clears on the next `load_start`.
- Assert `rst` at word 6. Required response: all outputs 0 next cycle and `in_ready=0`; a subsequent full load succeeds.
- With `PARAM_READBACK_EN` defined, after the first test, `rd_addr=3` gives `rd_data=0x00008000` one cycle later.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared loader state type and neuron word-slot constants
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } ldr_state_t;

    localparam int WORDS_PER_NEURON = 4;

    localparam int SLOT_W1 = 0;
    localparam int SLOT_W2 = 1;
    localparam int SLOT_B1 = 2;
    localparam int SLOT_B2 = 3;

endpackage

// File: rtl/param_shadow_bank.sv
// rtl/param_shadow_bank.sv - shadow and active parameter arrays with atomic commit
module param_shadow_bank import nn_pkg::*; #(
    parameter int WIDTH    = 32,
    parameter int N_NEURON = 2,
    parameter int TOTAL    = WORDS_PER_NEURON * N_NEURON,
    parameter int IDXW     = $clog2(TOTAL)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [IDXW-1:0]           wr_idx,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit,
    output logic [N_NEURON*WIDTH-1:0] w1_o,
    output logic [N_NEURON*WIDTH-1:0] w2_o,
    output logic [N_NEURON*WIDTH-1:0] b1_o,
    output logic [N_NEURON*WIDTH-1:0] b2_o
);

    logic [WIDTH-1:0] shadow [TOTAL];
    logic [WIDTH-1:0] active [TOTAL];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TOTAL; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                shadow[wr_idx] <= wr_data;
            end
            // The whole set moves in one edge so neurons never see a mix.
            if (commit) begin
                for (int i = 0; i < TOTAL; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    for (genvar k = 0; k < N_NEURON; k++) begin : g_neuron
        assign w1_o[k*WIDTH +: WIDTH] = active[k*WORDS_PER_NEURON + SLOT_W1];
        assign w2_o[k*WIDTH +: WIDTH] = active[k*WORDS_PER_NEURON + SLOT_W2];
        assign b1_o[k*WIDTH +: WIDTH] = active[k*WORDS_PER_NEURON + SLOT_B1];
        assign b2_o[k*WIDTH +: WIDTH] = active[k*WORDS_PER_NEURON + SLOT_B2];
    end

endmodule

// File: rtl/param_loader.sv
// rtl/param_loader.sv - streams neuron weights/biases into a shadow bank and commits atomically
// Optional active-bank readback port enabled by PARAM_READBACK_EN.
module param_loader import nn_pkg::*; #(
    parameter int WIDTH    = 32,
    parameter int N_NEURON = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic                      abort,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic [N_NEURON*WIDTH-1:0] w1_o,
    output logic [N_NEURON*WIDTH-1:0] w2_o,
    output logic [N_NEURON*WIDTH-1:0] b1_o,
    output logic [N_NEURON*WIDTH-1:0] b2_o,
    output logic                      busy,
    output logic                      done,
    output logic                      err
`ifdef PARAM_READBACK_EN
    ,
    input  logic [$clog2(WORDS_PER_NEURON*N_NEURON)-1:0] rd_addr,
    output logic [WIDTH-1:0]                             rd_data
`endif
);

    localparam int TOTAL = WORDS_PER_NEURON * N_NEURON;
    localparam int IDXW  = $clog2(TOTAL);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TOTAL - 1);

    ldr_state_t      state, state_d;
    logic [IDXW-1:0] idx, idx_d;
    logic            err_d;
    logic            done_d;
    logic            wr_en;
    logic            commit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            err   <= err_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        err_d   = err;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    err_d = 1'b1;
                end
                // Abort wins over a same-cycle handshake: that word is dropped.
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    wr_en = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_d = COMMIT;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            COMMIT: begin
                if (load_start) begin
                    err_d = 1'b1;
                end
                commit  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);

    param_shadow_bank #(
        .WIDTH    (WIDTH),
        .N_NEURON (N_NEURON),
        .TOTAL    (TOTAL),
        .IDXW     (IDXW)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_data (in_data),
        .commit  (commit),
        .w1_o    (w1_o),
        .w2_o    (w2_o),
        .b1_o    (b1_o),
        .b2_o    (b2_o)
    );

`ifdef PARAM_READBACK_EN
    logic [WIDTH-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (int'(rd_addr) < TOTAL) begin
            case (int'(rd_addr) % WORDS_PER_NEURON)
                SLOT_W1: rd_word = w1_o[(int'(rd_addr) / WORDS_PER_NEURON) * WIDTH +: WIDTH];
                SLOT_W2: rd_word = w2_o[(int'(rd_addr) / WORDS_PER_NEURON) * WIDTH +: WIDTH];
                SLOT_B1: rd_word = b1_o[(int'(rd_addr) / WORDS_PER_NEURON) * WIDTH +: WIDTH];
                default: rd_word = b2_o[(int'(rd_addr) / WORDS_PER_NEURON) * WIDTH +: WIDTH];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_word;
        end
    end
`endif

endmodule

// File: tb/tb_param_loader.sv
// tb/tb_param_loader.sv - table, directed and randomized checks for param_loader
module tb_param_loader;

    localparam int W     = 32;
    localparam int NN    = 2;
    localparam int TOTAL = 8;

    logic          clk = 1'b0;
    logic          rst, load_start, abort, in_valid, in_ready;
    logic [W-1:0]  in_data;
    logic [NN*W-1:0] w1_o, w2_o, b1_o, b2_o;
    logic          busy, done, err;
`ifdef PARAM_READBACK_EN
    logic [2:0]    rd_addr;
    logic [W-1:0]  rd_data;
`endif

    always #5 clk = ~clk;

    param_loader #(.WIDTH(W), .N_NEURON(NN)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .w1_o       (w1_o),
        .w2_o       (w2_o),
        .b1_o       (b1_o),
        .b2_o       (b2_o),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef PARAM_READBACK_EN
        ,
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
`endif
    );

    typedef struct {
        logic [7:0][31:0] words;
        int               mode;
        int               exp_lat;
        logic [31:0]      exp_w1_0;
        logic [31:0]      exp_b2_1;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [7:0][31:0] exp_active;
    logic [7:0][31:0] cur_words;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected flattened output for one slot: neuron k's word sits at k*4+slot.
    function automatic logic [63:0] flat(input int slot);
        logic [63:0] r;
        for (int k = 0; k < NN; k++) r[k*32 +: 32] = exp_active[k*4 + slot];
        return r;
    endfunction

    task automatic chk_all(input string name);
        chk(name, {w1_o, w2_o, b1_o, b2_o}, {flat(0), flat(1), flat(2), flat(3)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: in_valid held high, 1: alternate stalls, 2: random stalls
    task automatic run_load(input int mode, input int abort_at, input int ls_at,
                            output int lat, output int stalls, output bit ls_fired,
                            output bit aborted);
        int  sent;
        int  c;
        bit  stall;
        bit  hs;
        sent = 0; lat = -1; stalls = 0; ls_fired = 0; aborted = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("err_clear_on_start", err, 0);
        c = 1;
        while (c < 200) begin
            if (done) begin
                lat = c;
                break;
            end
            chk("hold_old_set", {w1_o, w2_o, b1_o, b2_o}, {flat(0), flat(1), flat(2), flat(3)});
            chk("busy_in_load", busy, 1);
            in_valid = 1'b0; abort = 1'b0; load_start = 1'b0;
            if (sent < TOTAL) begin
                stall = (mode == 1) ? ((c - 1) % 2 == 1) :
                        (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
                in_valid = !stall;
                in_data  = stall ? $urandom : cur_words[sent];
                if (stall) stalls++;
                if (abort_at == sent) abort = 1'b1;
                if (ls_at == sent && !ls_fired) begin
                    load_start = 1'b1;
                    ls_fired   = 1'b1;
                end
            end
            hs = in_valid && in_ready;
            tick();
            if (abort) begin
                aborted = 1'b1;
                break;
            end
            if (hs) sent++;
            c++;
        end
        in_valid = 1'b0; abort = 1'b0; load_start = 1'b0;
        if (aborted) begin
            for (int i = 0; i < 12; i++) begin
                chk("abort_no_done", done, 0);
                chk("abort_idle", {busy, in_ready}, 2'b00);
                chk_all("abort_keeps_set");
                tick();
            end
        end
    endtask

    task automatic do_load(input int mode, input int abort_at, input int ls_at, output int lat);
        int stalls;
        bit lsf;
        bit ab;
        run_load(mode, abort_at, ls_at, lat, stalls, lsf, ab);
        if (!ab) begin
            chk("latency", lat, TOTAL + 2 + stalls);
            exp_active = cur_words;
            chk_all("commit_values");
            chk("done_cycle_idle", {busy, in_ready}, 2'b00);
        end
        chk("err_flag", err, lsf);
        if (!ab) begin
            tick();
            chk("done_one_cycle", done, 0);
            chk_all("values_after_done");
        end
    endtask

    logic [31:0] plan_w [8] = '{32'h00010000, 32'h00020000, 32'hFFFF0000, 32'h00008000,
                                32'h00030000, 32'h00040000, 32'h00000000, 32'h7FFFFFFF};
    logic [31:0] neg_w  [8] = '{32'h80000000, 32'hFFFFFFFF, 32'h12345678, 32'hDEADBEEF,
                                32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
    vec_t tbl [3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ab_at;
        int ls_at;
        rst = 1'b1; load_start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
`ifdef PARAM_READBACK_EN
        rd_addr = '0;
`endif
        exp_active = '0;
        for (int i = 0; i < 8; i++) begin
            tbl[0].words[i] = plan_w[i];
            tbl[1].words[i] = plan_w[i];
            tbl[2].words[i] = neg_w[i];
        end
        tbl[0].mode = 0; tbl[0].exp_lat = 10; tbl[0].exp_w1_0 = 32'h00010000; tbl[0].exp_b2_1 = 32'h7FFFFFFF;
        tbl[1].mode = 1; tbl[1].exp_lat = 17; tbl[1].exp_w1_0 = 32'h00010000; tbl[1].exp_b2_1 = 32'h7FFFFFFF;
        tbl[2].mode = 0; tbl[2].exp_lat = 10; tbl[2].exp_w1_0 = 32'h80000000; tbl[2].exp_b2_1 = 32'h00000004;

        tick(); tick();
        rst = 1'b0;
        chk_all("reset_outputs");
        chk("reset_flags", {in_ready, busy, done, err}, 4'b0000);

        for (int t = 0; t < 3; t++) begin
            cur_words = tbl[t].words;
            do_load(tbl[t].mode, -1, -1, lat);
            chk("tbl_latency", lat, tbl[t].exp_lat);
            chk("tbl_w1_0", w1_o[31:0], tbl[t].exp_w1_0);
            chk("tbl_b2_1", b2_o[63:32], tbl[t].exp_b2_1);
`ifdef PARAM_READBACK_EN
            if (t == 0) begin
                rd_addr = 3'd3;
                tick();
                chk("readback_addr3", rd_data, 32'h00008000);
                rd_addr = 3'd7;
                tick();
                chk("readback_addr7", rd_data, 32'h7FFFFFFF);
            end
`endif
        end

        // abort after 5 words leaves the previous set active
        for (int i = 0; i < 8; i++) cur_words[i] = $urandom;
        do_load(0, 5, -1, lat);

        // load_start at word 3 flags err but the load completes
        cur_words = tbl[0].words;
        do_load(0, -1, 3, lat);
        chk("err_load_latency", lat, 10);

        // reset during word 6
        for (int i = 0; i < 8; i++) cur_words[i] = $urandom;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("err_cleared_by_start", err, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = cur_words[i];
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_active = '0;
        chk_all("rst_mid_load_zero");
        chk("rst_mid_load_flags", {in_ready, busy, done, err}, 4'b0000);
        do_load(0, -1, -1, lat);
        chk("after_rst_latency", lat, 10);

        // randomized loads with stalls, aborts and stray load_start pulses
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 8; i++) cur_words[i] = $urandom;
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            ls_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            do_load(2, ab_at, ls_at, lat);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
